// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start/data/parity/stop decode with a
// valid/ready output register, parity and framing checks, and overrun pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | counting to the start-bit centre to reject glitches
// DATA   | sampling DATA_BITS payload bits, LSB first
// PARITY | sampling the parity bit (only when PARITY_EN = 1)
// STOP   | sampling STOP_BITS stop bits, then handing the frame over
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 rx_clock,
  input  logic                 rx_reset_n,
  input  logic                 rx_enable,
  input  logic                 rx_sample_tick,
  input  logic                 rx_input,
  output logic [DATA_BITS-1:0] rx_output,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_frame_error,
  output logic                 rx_parity_error,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   sync1_q, sync2_q;
  logic                   done;
  logic                   rx_s;

  logic [DATA_BITS-1:0]   out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   oferr_q, oferr_d;
  logic                   operr_q, operr_d;
  logic                   ovr_q, ovr_d;

  assign rx_s = sync2_q;

  always_ff @(posedge rx_clock or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_input;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge rx_clock or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    if (!rx_enable) begin
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else if (rx_sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        START: begin
          if (tick_q == HALF_M1) begin
            tick_d  = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        DATA: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_d   = '0;
              state_d = HAS_PAR ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        PARITY: begin
          if (tick_q == FULL_M1) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ rx_s ^ ODD;
            state_d = STOP;
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        STOP: begin
          if (tick_q == FULL_M1) begin
            tick_d = '0;
            ferr_d = ferr_q | ~rx_s;
            if (bit_q == LAST_STOP) begin
              // Back to IDLE right at the centre so a following start edge is not missed.
              bit_d   = '0;
              state_d = IDLE;
              done    = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion coinciding with acceptance replaces the held frame without overrun.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    oferr_d = oferr_q;
    operr_d = operr_q;
    ovr_d   = 1'b0;
    if (done && (!valid_q || rx_ready)) begin
      out_d   = shift_q;
      oferr_d = ferr_d;
      operr_d = perr_q;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      oferr_d = 1'b0;
      operr_d = 1'b0;
    end
  end

  always_ff @(posedge rx_clock or negedge rx_reset_n) begin
    if (!rx_reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      oferr_q <= 1'b0;
      operr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      oferr_q <= oferr_d;
      operr_q <= operr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_output       = out_q;
  assign rx_valid        = valid_q;
  assign rx_frame_error  = oferr_q;
  assign rx_parity_error = operr_q;
  assign rx_overrun      = ovr_q;
  assign rx_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: instance A is 8N1 x16 with a tick every clock, instance B is
// 8E2 x4 with a tick every third clock.
module tb_uart_rx_param;

  logic       clk_sys;
  logic       rst_n;
  logic       en;
  logic       tick_a, tick_b;
  logic       rxa, rxb;
  logic       readya, readyb;
  logic [7:0] da, db;
  logic       va, vb, busya, busyb, fea, feb, pea, peb, ova, ovb;

  int n_chk = 0;
  int n_pass = 0;
  int va_cnt = 0, vb_cnt = 0, ovr_cnt = 0;
  int busy_seen = 0;
  int tcnt = 0;
  logic [7:0] cap_da, cap_db;
  logic       cap_fa, cap_pa, cap_fb, cap_pb;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .rx_clock(clk_sys), .rx_reset_n(rst_n), .rx_enable(en), .rx_sample_tick(tick_a),
    .rx_input(rxa), .rx_output(da), .rx_valid(va), .rx_ready(readya), .rx_busy(busya),
    .rx_frame_error(fea), .rx_parity_error(pea), .rx_overrun(ova));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
    .rx_clock(clk_sys), .rx_reset_n(rst_n), .rx_enable(en), .rx_sample_tick(tick_b),
    .rx_input(rxb), .rx_output(db), .rx_valid(vb), .rx_ready(readyb), .rx_busy(busyb),
    .rx_frame_error(feb), .rx_parity_error(peb), .rx_overrun(ovb));

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    tick_b = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      tcnt   = (tcnt + 1) % 3;
      tick_b = (tcnt == 0);
    end
  end

  always @(negedge clk_sys) begin
    if (va) begin
      va_cnt++;
      cap_da = da;
      cap_fa = fea;
      cap_pa = pea;
    end
    if (vb) begin
      vb_cnt++;
      cap_db = db;
      cap_fb = feb;
      cap_pb = peb;
    end
    if (ova) ovr_cnt++;
    if (busya) busy_seen = 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive(input int sel, input logic b, input int clks);
    if (sel == 0) rxa = b;
    else rxb = b;
    repeat (clks) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic par,
                      input logic stop1, input logic stop2);
    int bp;
    bp = (sel == 0) ? 16 : 12;
    drive(sel, 1'b0, bp);
    for (int i = 0; i < 8; i++) drive(sel, d[i], bp);
    if (sel == 1) drive(sel, par, bp);
    drive(sel, stop1, bp);
    if (sel == 1) drive(sel, stop2, bp);
    drive(sel, 1'b1, 2 * bp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; tick_a = 1'b1;
    rxa = 1'b1; rxb = 1'b1; readya = 1'b1; readyb = 1'b1;
    #12;
    check("rst_out", {24'd0, da}, 32'h0);
    check("rst_flags", {26'd0, va, busya, fea, pea, ova, vb}, 32'h0);
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk_sys); #1;

    // 8N1 frame with ready held high
    va_cnt = 0;
    send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_data", {24'd0, cap_da}, 32'hA5);
    check("a5_vcycles", va_cnt, 1);
    check("a5_ferr", {31'd0, cap_fa}, 0);
    check("a5_perr", {31'd0, cap_pa}, 0);
    check("a5_busy", {31'd0, busya}, 0);

    // start-bit glitch
    va_cnt = 0; busy_seen = 0;
    rxa = 1'b0;
    repeat (5) @(posedge clk_sys); #1;
    rxa = 1'b1;
    repeat (30) @(posedge clk_sys); #1;
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_now", {31'd0, busya}, 0);
    check("glitch_valid", va_cnt, 0);
    check("glitch_ferr", {31'd0, fea}, 0);

    // even parity on instance B
    vb_cnt = 0;
    send(1, 8'h03, 1'b1, 1'b1, 1'b1);
    check("par1_data", {24'd0, cap_db}, 32'h03);
    check("par1_perr", {31'd0, cap_pb}, 1);
    check("par1_ferr", {31'd0, cap_fb}, 0);
    check("par1_vcnt", vb_cnt, 1);
    send(1, 8'h03, 1'b0, 1'b1, 1'b1);
    check("par0_perr", {31'd0, cap_pb}, 0);
    vb_cnt = 0;
    send(1, 8'h5A, 1'b0, 1'b1, 1'b0);
    check("stop2_data", {24'd0, cap_db}, 32'h5A);
    check("stop2_ferr", {31'd0, cap_fb}, 1);
    check("stop2_perr", {31'd0, cap_pb}, 0);
    check("stop2_vcnt", vb_cnt, 1);

    // framing error on instance A
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check("stop1_data", {24'd0, cap_da}, 32'h5A);
    check("stop1_ferr", {31'd0, cap_fa}, 1);

    // overrun with ready low
    readya = 1'b0; ovr_cnt = 0;
    send(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1, 1'b1);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_held", {24'd0, da}, 32'h11);
    check("ovr_valid", {31'd0, va}, 1);
    readya = 1'b1;
    @(posedge clk_sys); #1;
    check("accept_valid", {31'd0, va}, 0);
    check("accept_hold", {24'd0, da}, 32'h11);

    // async reset during DATA
    readya = 1'b0;
    send(0, 8'h77, 1'b0, 1'b1, 1'b1);
    rxa = 1'b0;
    repeat (64) @(posedge clk_sys); #1;
    check("mid_busy", {31'd0, busya}, 1);
    check("mid_valid_pre", {31'd0, va}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", {24'd0, da}, 32'h0);
    check("arst_flags", {27'd0, va, busya, fea, pea, ova}, 32'h0);
    rxa = 1'b1;
    repeat (3) @(posedge clk_sys); #1;
    rst_n = 1'b1; readya = 1'b1; va_cnt = 0;
    repeat (5) @(posedge clk_sys); #1;
    send(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    check("c3_data", {24'd0, cap_da}, 32'hC3);
    check("c3_vcnt", va_cnt, 1);

    // enable abort keeps held frame
    readya = 1'b0;
    send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    rxa = 1'b0;
    repeat (40) @(posedge clk_sys); #1;
    check("en_busy_pre", {31'd0, busya}, 1);
    en = 1'b0;
    @(posedge clk_sys); #1;
    check("en_busy", {31'd0, busya}, 0);
    check("en_valid", {31'd0, va}, 1);
    check("en_held", {24'd0, da}, 32'h3C);
    rxa = 1'b1;
    repeat (5) @(posedge clk_sys); #1;
    en = 1'b1;
    repeat (20) @(posedge clk_sys); #1;
    check("en_idle", {31'd0, busya}, 0);
    readya = 1'b1; va_cnt = 0;
    @(posedge clk_sys); #1;
    send(0, 8'h96, 1'b0, 1'b1, 1'b1);
    check("en_recover", {24'd0, cap_da}, 32'h96);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver. Data width, oversampling ratio, parity mode and stop-bit count are configurable. Adds an external sample-tick enable, parity checking, a valid/ready output handshake and overrun detection. It sits between the asynchronous serial pin and the fabric-side consumer, and replaces the fixed 8N1 receiver in new designs.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9; LSB first on the line.
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
PARITY_EN, 0, 1 = parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.

Ports:
rx_clock  input  1  Single clock for all logic.
rx_reset_n  input  1  Reset, asynchronous, active-low.
rx_enable  input  1  Synchronous enable; low aborts any frame in progress.
rx_sample_tick  input  1  One-cycle strobe at baud*OVERSAMPLE; tie to 1 to sample every clock.
rx_input  input  1  Asynchronous serial line; idles high.
rx_output  output  DATA_BITS  Received payload.
rx_valid  output  1  rx_output and the error flags hold a frame.
rx_ready  input  1  Consumer accepts the frame when rx_valid & rx_ready.
rx_busy  output  1  A frame is in progress.
rx_frame_error  output  1  Stop bit sampled low in the held frame.
rx_parity_error  output  1  Parity mismatch in the held frame.
rx_overrun  output  1  One-cycle pulse: a frame was dropped because rx_valid was still high.

Behaviour:
- Reset (rx_reset_n low, asynchronous): 2-flop synchroniser set to 1, FSM to IDLE, counters 0. All outputs 0: rx_output, rx_valid, rx_busy, both error flags, rx_overrun.
- rx_input passes through the 2-flop synchroniser; all decisions use the synchronised bit.
- Tick counter is $clog2(OVERSAMPLE) bits wide and advances only on cycles where rx_sample_tick = 1. The FSM waits on ticks.
- IDLE: rx_busy = 0. On a tick with the synchronised line low and rx_enable = 1, go to START with tick count 0 and set rx_busy = 1.
- START: at tick count OVERSAMPLE/2-1 (bit centre), re-sample the line.
  - Line high: glitch; return to IDLE, rx_busy = 0, no flags raised.
  - Line low: go to DATA with tick count 0.
- DATA: sample at every OVERSAMPLE-th tick (bit centres) into the shift register, LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN = 1, otherwise to STOP.
- PARITY: sample one bit. Error = (XOR of data bits XOR parity bit) != PARITY_ODD.
- STOP: sample STOP_BITS centres.
  - Frame error is set if any stop sample is low.
  - After the final stop centre, return to IDLE immediately, so the next start edge can arrive within half a bit.
- Completion (cycle after the final stop-centre tick):
  - If rx_valid = 0: load rx_output, rx_frame_error and rx_parity_error, and set rx_valid = 1. Data is delivered even when either error flag is set.
  - If rx_valid = 1: discard the new frame, keep the held frame unchanged, pulse rx_overrun high for 1 cycle.
- Handshake:
  - rx_valid stays high until a clock with rx_valid & rx_ready.
  - On that edge rx_valid and both error flags clear. rx_output holds its last value.
  - A completion in the same cycle as acceptance loads the new frame with rx_valid kept at 1. No overrun is reported in that case.
- rx_enable low: on the next edge the FSM goes to IDLE, counters clear and rx_busy = 0. The held output and rx_valid are unaffected.
- Latency: rx_valid rises exactly 1 rx_clock after the final stop-centre tick.
- rx_sample_tick low for arbitrary stretches freezes the FSM. Behaviour is identical to a slower baud.

Test Plan:
- 8N1, OVERSAMPLE=16, tick=1: send 0xA5, rx_ready=1. Expect rx_output=0xA5 and rx_valid high for 1 cycle; both error flags 0; rx_busy low after the stop centre.
- Line low for 5 ticks then high: rx_busy pulses, then returns to 0. rx_valid stays 0 and no error flags are raised.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1. Expect rx_output=0x03, rx_parity_error=1. Repeat with parity bit 0: rx_parity_error=0.
- Stop bit driven low for 0x5A: rx_output=0x5A, rx_frame_error=1. With STOP_BITS=2 and only the second stop bit low, still expect rx_frame_error=1.
- rx_ready=0, send 0x11 then 0x22 back-to-back. Expect rx_output=0x11 held and a single-cycle rx_overrun at the 0x22 completion. Raising rx_ready clears rx_valid.
- rx_reset_n low mid-DATA: all outputs 0 immediately (asynchronous). After release, a fresh 0xC3 frame is received correctly. Repeat the abort with rx_enable low: the held frame is kept.
